seq_alu: RTL and testbench

Parametrised multi-cycle successor to the single-cycle ALU. It adds valid/ready handshakes on both sides, a registered result, and iterative unsigned multiply/divide. It sits between operand-fetch and writeback in the multi-cycle datapath. All arithmetic and logic ops complete in one cycle; multiply and divide stall for WIDTH cycles.

---
 rtl/alu_pkg.sv | 12 +
 rtl/seq_muldiv.sv | 54 +++++
 rtl/seq_alu.sv | 96 +++++++++
 tb/tb_seq_alu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM states shared by the seq_alu datapath
package alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SRL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned shift-add multiply / restoring divide, one step per cycle
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH + 1);
  logic             busy_q, busy_d, div_q, div_d, quo_bit;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, src_hi, src_lo;
  logic [WIDTH:0]   sum, sh;
  logic [CW-1:0]    cnt_q, cnt_d;
  // The first step runs on the load edge, so WIDTH steps fit in WIDTH-1 busy cycles
  always_comb begin
    div_d   = start ? div : div_q;
    m_d     = start ? (div ? b : a) : m_q;
    src_hi  = start ? '0 : hi_q;
    src_lo  = start ? (div ? a : b) : lo_q;
    sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, m_d} : '0);
    sh      = {src_hi, src_lo[WIDTH-1]};
    quo_bit = sh >= {1'b0, m_d};
    hi      = div_d ? (quo_bit ? sh[WIDTH-1:0] - m_d : sh[WIDTH-1:0]) : sum[WIDTH:1];
    lo      = div_d ? {src_lo[WIDTH-2:0], quo_bit} : {sum[0], src_lo[WIDTH-1:1]};
    done    = busy_q && cnt_q == CW'(WIDTH - 1);
    busy_d  = start | (busy_q & ~done);
    cnt_d   = start ? CW'(1) : busy_q ? cnt_q + CW'(1) : cnt_q;
    hi_d    = (start | busy_q) ? hi : hi_q;
    lo_d    = (start | busy_q) ? lo : lo_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      m_q    <= m_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked registered ALU; define SEQ_ALU_MULDIV_EN to build iterative MULU/DIVU
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D
);
  localparam int SW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d, d_q, d_d, alu_c, alu_d, md_lo, md_hi;
  logic [SW-1:0]    shamt;
  logic             accept, start, md_done;
  assign in_ready  = state_q == ST_IDLE || (state_q == ST_DONE && out_ready);
  assign out_valid = state_q == ST_DONE;
  assign accept    = in_valid & in_ready;
  assign shamt     = B[SW-1:0];
  assign C         = c_q;
  assign D         = d_q;
  always_comb begin
    alu_c = '0;
    alu_d = '0;
    case (ALUOp)
      OP_ADD:  alu_c = A + B;
      OP_SUB:  alu_c = A - B;
      OP_AND:  alu_c = A & B;
      OP_OR:   alu_c = A | B;
      OP_SRL:  alu_c = A >> shamt;
      OP_SRA:  alu_c = $signed(A) >>> shamt;
`ifdef SEQ_ALU_MULDIV_EN
      OP_DIVU: begin
        alu_c = '1;
        alu_d = A;
      end
`endif
      default: ;
    endcase
  end
`ifdef SEQ_ALU_MULDIV_EN
  // A zero B skips the iteration: MULU yields 0 and DIVU the divide-by-zero pattern
  assign start = accept && ALUOp[2:1] == 2'b11 && B != '0;
  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .div     (ALUOp[0]),
    .a       (A),
    .b       (B),
    .done    (md_done),
    .lo      (md_lo),
    .hi      (md_hi)
  );
`else
  assign start   = 1'b0;
  assign md_done = 1'b0;
  assign md_lo   = '0;
  assign md_hi   = '0;
`endif
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    if (state_q == ST_BUSY) begin
      state_d = md_done ? ST_DONE : ST_BUSY;
      c_d     = md_done ? md_lo : c_q;
      d_d     = md_done ? md_hi : d_q;
    end else if (accept) begin
      state_d = start ? ST_BUSY : ST_DONE;
      c_d     = start ? c_q : alu_c;
      d_d     = start ? d_q : alu_d;
    end else if (state_q == ST_DONE && out_ready) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed scoreboard bench for seq_alu, adapts to SEQ_ALU_MULDIV_EN
module tb_seq_alu;
  import alu_pkg::*;
  localparam int W = 32;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int MD_LAT = MD ? W : 1;

  logic         clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid;
  logic [W-1:0] A = '0, B = '0, C, D;
  logic [2:0]   ALUOp = '0;
  int           tests = 0, fails = 0, cyc = 0, c0, w;

  typedef struct {
    logic [W-1:0] c;
    logic [W-1:0] d;
    string        name;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .D         (D)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result handed to the consumer is matched against the oldest expectation
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got C=0x%0h D=0x%0h, expected no result", C, D);
      end else begin
        e = sb.pop_front();
        chk(e.name, {C, D}, {e.c, e.d});
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ec, input logic [W-1:0] ed, input string name,
                       output int waited);
    A = a;
    B = b;
    ALUOp = op;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: in_ready got 0, expected 1 within 100 cycles", name);
    end else begin
      sb.push_back('{c: ec, d: ed, name: name});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic go(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] ec, input logic [W-1:0] ed, input string name);
    int wt;
    issue(op, a, b, ec, ed, name, wt);
  endtask

  task automatic wait_valid(input int exp_lat, input string name);
    int n = 0;
    bit busy_ok = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (in_ready) busy_ok = 1'b0;
    end
    chk({name, "_latency"}, n, exp_lat);
    if (exp_lat > 1) chk({name, "_in_ready_low"}, busy_ok, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_C", C, 0);
    chk("rst_D", D, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    go(OP_ADD, 5, 63, 68, 0, "add");                          wait_valid(1, "add");
    go(OP_SUB, 79, 63, 16, 0, "sub");                         wait_valid(1, "sub");
    go(OP_SRA, 32'hAA87199A, 7, 32'hFF550E33, 0, "sra");      wait_valid(1, "sra");
    go(OP_SRL, 32'hAA87199A, 7, 32'h01550E33, 0, "srl");      wait_valid(1, "srl");

    c0 = cyc;
    go(OP_SRL, 32'hAA87199A, 32'h27, 32'h01550E33, 0, "srl_upper_b_ignored");
    go(OP_SRA, 32'h80000000, 31, 32'hFFFFFFFF, 0, "sra_max");
    go(OP_AND, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 0, "and");
    go(OP_OR,  32'hF0F01234, 32'h0FF0FFFF, 32'hFFF0FFFF, 0, "or");
    go(OP_ADD, 32'hFFFFFFFF, 2, 1, 0, "add_wrap");
    go(OP_SUB, 0, 1, 32'hFFFFFFFF, 0, "sub_wrap");
    chk("throughput_cycles", cyc - c0, 6);
    wait_valid(1, "sub_wrap");

    go(OP_MULU, 32'hFFFFFFFF, 2, MD ? 32'hFFFFFFFE : 32'h0, MD ? 32'h1 : 32'h0, "mulu");
    wait_valid(MD_LAT, "mulu");
    go(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, MD ? 32'h1 : 32'h0, MD ? 32'hFFFFFFFE : 32'h0, "mulu_max");
    wait_valid(MD_LAT, "mulu_max");
    go(OP_MULU, 32'h10000, 32'h10000, 0, MD ? 32'h1 : 32'h0, "mulu_carry");
    wait_valid(MD_LAT, "mulu_carry");
    go(OP_DIVU, 100, 7, MD ? 32'd14 : 32'd0, MD ? 32'd2 : 32'd0, "divu");
    wait_valid(MD_LAT, "divu");
    go(OP_DIVU, 9, 0, MD ? 32'hFFFFFFFF : 32'h0, MD ? 32'd9 : 32'd0, "divu_by_zero");
    wait_valid(1, "divu_by_zero");
    go(OP_DIVU, 32'hFFFFFFFF, 1, MD ? 32'hFFFFFFFF : 32'h0, 0, "divu_by_one");
    wait_valid(MD_LAT, "divu_by_one");
    go(OP_DIVU, 5, 9, 0, MD ? 32'd5 : 32'd0, "divu_small");
    wait_valid(MD_LAT, "divu_small");
    go(OP_DIVU, 32'hFFFFFFFF, 16, MD ? 32'h0FFFFFFF : 32'h0, MD ? 32'hF : 32'h0, "divu_by_16");
    wait_valid(MD_LAT, "divu_by_16");

    out_ready = 1'b0;
    go(OP_ADD, 1, 2, 3, 0, "bp_old");
    wait_valid(1, "bp_old");
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, C, D}, {1'b1, 1'b0, 32'd3, 32'd0});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(OP_ADD, 10, 20, 30, 0, "bp_new", w);
    chk("bp_same_edge_accept", w, 0);
    wait_valid(1, "bp_new");

`ifdef SEQ_ALU_MULDIV_EN
    go(OP_MULU, 32'hFFFFFFFF, 3, 32'hFFFFFFFD, 32'h2, "mulu_aborted");
    repeat (10) @(negedge clk);
    chk("busy_before_reset", {out_valid, in_ready}, 2'b00);
`else
    out_ready = 1'b0;
    go(OP_ADD, 7, 8, 15, 0, "held_aborted");
    repeat (10) @(negedge clk);
    chk("held_before_reset", C, 15);
`endif
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_C", C, 0);
    chk("abort_D", D, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    go(OP_ADD, 100, 23, 123, 0, "add_after_reset");
    wait_valid(1, "add_after_reset");

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
